// File: rtl/blinker_led_pkg.sv
// Shared register map and STATUS layout for the blinking LED driver.
// Both the register file and the bench-facing address decode use these constants.
package blinker_led_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_PERIOD     = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_TCNT_LSB  = 8;
    localparam int STATUS_TCNT_W    = 8;

    function automatic logic [31:0] pack_status(input logic phase,
                                                input logic [STATUS_TCNT_W-1:0] toggle_count);
        logic [31:0] word;
        word = '0;
        word[STATUS_PHASE_BIT] = phase;
        word[STATUS_TCNT_LSB +: STATUS_TCNT_W] = toggle_count;
        return word;
    endfunction

endpackage

// File: rtl/blinker_led_timer.sv
// Blink timer: counts half-periods of PERIOD cycles, toggling phase and
// counting toggles. clear (STATUS write) outranks load (PERIOD write) outranks counting.
module blinker_led_timer
    import blinker_led_pkg::*;
#(
    parameter int CNT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CNT_WIDTH-1:0]     period,
    input  logic                     load,
    input  logic                     clear,
    output logic                     phase,
    output logic [STATUS_TCNT_W-1:0] toggle_count
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]     count_reg, count_next;
    logic                     phase_reg, phase_next;
    logic [STATUS_TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic                     terminal;

    assign terminal = (period != '0) && (count_reg >= period - ONE);

    always_comb begin
        count_next = count_reg;
        phase_next = phase_reg;
        tcnt_next  = tcnt_reg;
        if (clear) begin
            count_next = '0;
            phase_next = 1'b0;
            tcnt_next  = '0;
        end else if (load) begin
            // New period restarts the half-period; phase is deliberately kept.
            count_next = '0;
        end else if (period == '0) begin
            count_next = '0;
            phase_next = 1'b0;
        end else if (terminal) begin
            count_next = '0;
            phase_next = ~phase_reg;
            tcnt_next  = tcnt_reg + 8'd1;
        end else begin
            count_next = count_reg + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
            phase_reg <= 1'b0;
            tcnt_reg  <= '0;
        end else begin
            count_reg <= count_next;
            phase_reg <= phase_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    assign phase        = phase_reg;
    assign toggle_count = tcnt_reg;

endmodule

// File: rtl/blinker_led_driver.sv
// Avalon-MM slave LED driver: DATA/BLINK_MASK/PERIOD registers, atomic set/clear
// aliases, registered read mux and a registered blinking output.
module blinker_led_driver
    import blinker_led_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CNT_WIDTH   = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    wdata_d;
    logic [CNT_WIDTH-1:0]     wdata_c;
    logic [DATA_WIDTH-1:0]    data_reg, data_next;
    logic [DATA_WIDTH-1:0]    mask_reg, mask_next;
    logic [CNT_WIDTH-1:0]     period_reg, period_next;
    logic [31:0]              readdata_reg, readdata_next;
    logic [DATA_WIDTH-1:0]    out_port_reg, out_port_next;
    logic                     phase;
    logic [STATUS_TCNT_W-1:0] toggle_count;

    assign wr_en   = chipselect & ~write_n;
    assign wdata_d = writedata[DATA_WIDTH-1:0];
    assign wdata_c = writedata[CNT_WIDTH-1:0];

    blinker_led_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .period      (period_reg),
        .load        (wr_en && (address == ADDR_PERIOD)),
        .clear       (wr_en && (address == ADDR_STATUS)),
        .phase       (phase),
        .toggle_count(toggle_count)
    );

    always_comb begin
        data_next   = data_reg;
        mask_next   = mask_reg;
        period_next = period_reg;
        if (wr_en) begin
            case (address)
                ADDR_DATA:       data_next   = wdata_d;
                ADDR_BLINK_MASK: mask_next   = wdata_d;
                ADDR_PERIOD:     period_next = wdata_c;
                ADDR_OUTSET:     data_next   = data_reg | wdata_d;
                ADDR_OUTCLEAR:   data_next   = data_reg & ~wdata_d;
                default:         ;
            endcase
        end
    end

    // Read mux samples pre-write register values, giving one cycle of latency.
    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:       readdata_next[DATA_WIDTH-1:0] = data_reg;
            ADDR_BLINK_MASK: readdata_next[DATA_WIDTH-1:0] = mask_reg;
            ADDR_PERIOD:     readdata_next[CNT_WIDTH-1:0]  = period_reg;
            ADDR_STATUS:     readdata_next = pack_status(phase, toggle_count);
            default:         readdata_next = '0;
        endcase
    end

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
        assign out_port_next[gi] = data_reg[gi] ^ (mask_reg[gi] & phase);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg     <= RESET_VALUE;
            mask_reg     <= '0;
            period_reg   <= '0;
            readdata_reg <= '0;
            out_port_reg <= RESET_VALUE;
        end else begin
            data_reg     <= data_next;
            mask_reg     <= mask_next;
            period_reg   <= period_next;
            readdata_reg <= readdata_next;
            out_port_reg <= out_port_next;
        end
    end

    assign readdata = readdata_reg;
    assign out_port = out_port_reg;

endmodule

// File: doc/blinker_led_driver.md
BLINKER_LED_DRIVER -- requirements
Module: blinker_led_driver

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of out_port and of the DATA, BLINK_MASK, OUTSET and OUTCLEAR registers.
REQ-002 Parameter CNT_WIDTH, default 24: width of PERIOD and of the blink counter.
REQ-003 Parameter RESET_VALUE, default 0: DATA register value after reset.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 Port address, input, 3: Avalon-MM s1 word address.
REQ-007 Port chipselect, input, 1: s1 select.
REQ-008 Port write_n, input, 1: active-low write strobe, qualified by chipselect.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port readdata, output, 32: registered read data.
REQ-011 Port out_port, output, DATA_WIDTH: registered LED drive.

Function
REQ-012 Write occurs on a cycle with chipselect=1 and write_n=0; no wait states; writedata bits above each register's width are ignored.
REQ-013 Address map: 0 DATA (RW), 1 BLINK_MASK (RW), 2 PERIOD (RW), 3 STATUS (RW), 4 OUTSET (WO), 5 OUTCLEAR (WO), 6-7 reserved (writes ignored, reads 0).
REQ-014 Write to OUTSET sets DATA <= DATA | writedata; write to OUTCLEAR sets DATA <= DATA & ~writedata; both read as 0.
REQ-015 readdata updates every cycle, regardless of chipselect, from the addressed register; unused upper bits are zero; latency is one cycle.
REQ-016 STATUS read: bit0 = phase, bits[15:8] = toggle_count (8-bit, wraps 255->0), other bits 0.
REQ-017 Any write to STATUS clears phase and toggle_count to 0 and the counter to 0 in the following cycle.
REQ-018 Blink timer with PERIOD=0: counter and phase are held at 0 and toggle_count is held.
REQ-019 Blink timer with PERIOD=N>0: counter increments each cycle; when counter >= N-1, counter goes to 0, phase toggles, and toggle_count increments; the half-period is therefore exactly N cycles.
REQ-020 A write to PERIOD loads the new value and forces counter to 0 with phase unchanged; when it coincides with terminal count, the write wins and no toggle occurs.
REQ-021 When a STATUS write and a terminal count coincide, the clear wins.
REQ-022 out_port <= DATA ^ (BLINK_MASK & {DATA_WIDTH{phase}}), registered; a register write is visible on out_port two cycles after the write cycle.
REQ-023 With BLINK_MASK=0, out_port equals DATA independent of phase.

Reset
REQ-024 While reset_n=0 at a clock edge: DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, counter=0, phase=0, toggle_count=0, readdata=0, out_port=RESET_VALUE.
REQ-025 Reset asserted mid-blink or concurrently with a write discards the write and applies REQ-024 values at that edge.

Structure
REQ-026 Package blinker_led_pkg holds the register address constants (ADDR_DATA..ADDR_OUTCLEAR) and the STATUS field bit positions.
REQ-027 Counter, phase and toggle_count reside in sub-module blinker_led_timer, with inputs period, load (PERIOD write) and clear (STATUS write), and outputs phase and toggle_count.
REQ-028 Register file, read mux and out_port logic reside in blinker_led_driver.

Verification
REQ-029 Reset, then read addresses 0-7 -> readdata is 0 for every address and out_port=RESET_VALUE.
REQ-030 Write DATA=0xA5, then OUTSET=0x0F, then OUTCLEAR=0x81 -> DATA reads 0xA5, 0xAF, 0x2E and out_port follows each value two cycles after the write.
REQ-031 PERIOD=4, BLINK_MASK=0xFF, DATA=0x00 -> out_port alternates 0x00/0xFF every 4 cycles and STATUS[15:8] increments per toggle, wrapping after 256 toggles.
REQ-032 PERIOD=5, then PERIOD write issued on the terminal-count cycle -> no toggle that cycle and the next toggle occurs exactly N cycles after the write.
REQ-033 STATUS write coincident with terminal count -> phase=0 and toggle_count=0; PERIOD=0 -> phase stays 0 indefinitely.
REQ-034 reset_n pulsed low for one cycle mid-blink with a simultaneous DATA write -> all REQ-024 values and the write discarded.
